// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: latency-1 ops plus iterative shift-add MUL behind a valid/ready handshake.
// Optional ALU_EXEC_ZERO_FLAG_EN adds a registered out_zero flag alongside out_result.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_aluop,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
`ifdef ALU_EXEC_ZERO_FLAG_EN
  output logic             out_zero,
`endif
  output logic             busy
);

  typedef enum logic {IDLE, MUL} state_t;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_SLT  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_XOR  = 3'b111;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH-1);

  state_t           state, state_n;
  logic             accept, out_fire, is_mul, load, slt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] mcand, mult, acc, acc_n;
  logic [WIDTH-1:0] alu_res, load_val;

  assign out_fire = out_valid && out_ready;
  assign in_ready = !rst && (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mul   = (in_aluop == OP_MUL);
  assign busy     = (state == MUL);
  assign slt      = $signed(in_a) < $signed(in_b);
  assign acc_n    = mult[0] ? acc + mcand : acc;

  always_comb begin
    alu_res = '0;
    unique case (in_aluop)
      OP_PASS: alu_res = in_b;
      OP_ADD:  alu_res = in_a + in_b;
      OP_SUB:  alu_res = in_a - in_b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt};
      OP_AND:  alu_res = in_a & in_b;
      OP_OR:   alu_res = in_a | in_b;
      OP_MUL:  alu_res = '0;
      OP_XOR:  alu_res = in_a ^ in_b;
    endcase
  end

  always_comb begin
    state_n  = state;
    load     = 1'b0;
    load_val = alu_res;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (is_mul) state_n = MUL;
          else        load    = 1'b1;
        end
      end
      MUL: begin
        if (cnt == LAST) begin
          load     = 1'b1;
          load_val = acc_n;
          state_n  = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      acc   <= '0;
      mcand <= '0;
      mult  <= '0;
    end else if (state == IDLE) begin
      if (accept && is_mul) begin
        mcand <= in_a;
        mult  <= in_b;
        acc   <= '0;
        cnt   <= '0;
      end
    end else begin
      acc   <= acc_n;
      mcand <= mcand << 1;
      mult  <= mult >> 1;
      cnt   <= cnt + CNT_W'(1);
    end
  end

  // A new result wins over the clear, so completion during a handshake leaves no bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
`ifdef ALU_EXEC_ZERO_FLAG_EN
      out_zero   <= 1'b0;
`endif
    end else if (load) begin
      out_valid  <= 1'b1;
      out_result <= load_val;
`ifdef ALU_EXEC_ZERO_FLAG_EN
      out_zero   <= (load_val == '0);
`endif
    end else if (out_fire) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit (WIDTH=32).
// Define ALU_EXEC_ZERO_FLAG_EN to also cover out_zero.
module tb_alu_exec_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_aluop;
  logic [W-1:0] in_a, in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         busy;
`ifdef ALU_EXEC_ZERO_FLAG_EN
  logic         out_zero;
`endif

  int pass_cnt = 0;
  int total    = 0;

  alu_exec_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_aluop   (in_aluop),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
`ifdef ALU_EXEC_ZERO_FLAG_EN
    .out_zero   (out_zero),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    in_valid = 1'b1;
    in_aluop = op;
    in_a     = a;
    in_b     = b;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_aluop = '0;
    in_a = '0; in_b = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || out_result !== '0 || busy !== 1'b0) begin
      $display("FAIL reset_state: valid=%b result=%h busy=%b req 0/0/0",
               out_valid, out_result, busy);
    end else pass_cnt++;
    total++;
    if (in_ready !== 1'b0)
      $display("FAIL reset_in_ready: got %b req 0", in_ready);
    else pass_cnt++;
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1)
      $display("FAIL post_reset_in_ready: got %b req 1", in_ready);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    logic [2:0]   ops [5];
    logic [W-1:0] as  [5];
    logic [W-1:0] bs  [5];
    logic [W-1:0] exp [5];
    ops[0] = 3'b001; as[0] = 32'd5;       bs[0] = 32'd7;       exp[0] = 32'd12;
    ops[1] = 3'b100; as[1] = 32'hF0F0;    bs[1] = 32'hFF00;    exp[1] = 32'hF000;
    ops[2] = 3'b111; as[2] = 32'hFF;      bs[2] = 32'h0F;      exp[2] = 32'hF0;
    ops[3] = 3'b000; as[3] = 32'hDEAD;    bs[3] = 32'h1234;    exp[3] = 32'h1234;
    ops[4] = 3'b101; as[4] = 32'h8000_0000; bs[4] = 32'h1;     exp[4] = 32'h8000_0001;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(ops[i], as[i], bs[i]);
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_result !== exp[i] || busy !== 1'b0)
        $display("FAIL b2b_%0d: valid=%b result=%h busy=%b req 1/%h/0",
                 i, out_valid, out_result, busy, exp[i]);
      else pass_cnt++;
    end
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || out_result !== exp[4])
      $display("FAIL b2b_clear: valid=%b result=%h req 0/%h",
               out_valid, out_result, exp[4]);
    else pass_cnt++;
  endtask

  task automatic test_arith;
    logic [2:0]   ops [3];
    logic [W-1:0] as  [3];
    logic [W-1:0] bs  [3];
    logic [W-1:0] exp [3];
    ops[0] = 3'b010; as[0] = 32'd3;          bs[0] = 32'd5;          exp[0] = 32'hFFFF_FFFE;
    ops[1] = 3'b011; as[1] = 32'hFFFF_FFFF;  bs[1] = 32'd1;          exp[1] = 32'd1;
    ops[2] = 3'b011; as[2] = 32'd1;          bs[2] = 32'hFFFF_FFFF;  exp[2] = 32'd0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(ops[i], as[i], bs[i]);
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_result !== exp[i])
        $display("FAIL arith_%0d: valid=%b result=%h req 1/%h",
                 i, out_valid, out_result, exp[i]);
      else pass_cnt++;
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int bad = 0;
    out_ready = 1'b0;
    drive(3'b101, 32'hF0, 32'h0F);
    @(negedge clk);
    drive(3'b001, 32'd1, 32'd1);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_result !== 32'hFF || in_ready !== 1'b0) begin
        $display("FAIL bp_hold_%0d: valid=%b result=%h in_ready=%b req 1/ff/0",
                 i, out_valid, out_result, in_ready);
        bad++;
      end else pass_cnt++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1)
      $display("FAIL bp_release_in_ready: got %b req 1", in_ready);
    else pass_cnt++;
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_result !== 32'd2)
      $display("FAIL bp_no_bubble: valid=%b result=%h req 1/2",
               out_valid, out_result);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || out_result !== 32'd2)
      $display("FAIL bp_clear: valid=%b result=%h req 0/2",
               out_valid, out_result);
    else pass_cnt++;
  endtask

  task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp, input int id);
    out_ready = 1'b1;
    drive(3'b110, a, b);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      total++;
      if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
        $display("FAIL mul%0d_busy_c%0d: busy=%b in_ready=%b valid=%b req 1/0/0",
                 id, i, busy, in_ready, out_valid);
      end else pass_cnt++;
      if (i < W - 1) @(negedge clk);
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || out_result !== exp || busy !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL mul%0d_result: valid=%b result=%h busy=%b in_ready=%b req 1/%h/0/1",
               id, out_valid, out_result, busy, in_ready, exp);
    else pass_cnt++;
  endtask

  task automatic test_mul;
    run_mul(32'h1234, 32'h10, 32'h12340, 0);
    run_mul(32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || out_result !== 32'hFFFF_FFFE)
      $display("FAIL mul_clear: valid=%b result=%h req 0/fffffffe",
               out_valid, out_result);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_mul;
    int seen = 0;
    out_ready = 1'b1;
    drive(3'b110, 32'h55, 32'h3);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL midmul_reset: busy=%b valid=%b in_ready=%b req 0/0/0",
               busy, out_valid, in_ready);
    else pass_cnt++;
    rst = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    total++;
    if (seen != 0)
      $display("FAIL midmul_no_output: %0d stray cycles req 0", seen);
    else pass_cnt++;
    drive(3'b001, 32'd1, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_result !== 32'd2)
      $display("FAIL midmul_add: valid=%b result=%h req 1/2",
               out_valid, out_result);
    else pass_cnt++;
    @(negedge clk);
  endtask

`ifdef ALU_EXEC_ZERO_FLAG_EN
  task automatic test_zero_flag;
    out_ready = 1'b1;
    drive(3'b111, 32'hA5A5, 32'hA5A5);
    @(negedge clk);
    total++;
    if (out_result !== 32'd0 || out_zero !== 1'b1)
      $display("FAIL zero_set: result=%h zero=%b req 0/1", out_result, out_zero);
    else pass_cnt++;
    drive(3'b001, 32'd1, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (out_result !== 32'd2 || out_zero !== 1'b0)
      $display("FAIL zero_clr: result=%h zero=%b req 2/0", out_result, out_zero);
    else pass_cnt++;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset;
    test_back_to_back;
    test_arith;
    test_backpressure;
    test_mul;
    test_reset_mid_mul;
`ifdef ALU_EXEC_ZERO_FLAG_EN
    test_zero_flag;
`endif
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
